// File: rtl/input_circular_buffer.sv
// Circular FIFO feeding the scratchpad read-buffer controller.
// Pushes are accepted while not full; pops use a read_req/valid handshake with a registered dout.
module input_circular_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  wen,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  full,
   input  logic                  read_req,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty,
   output logic [ADDR_W:0]       count,
   output logic                  overflow
);

   // state   | meaning
   // IDLE    | waiting for read_req with a non-empty buffer
   // DELIVER | dout holds the popped word, valid high; read_req ignored

   typedef enum logic {IDLE = 1'b0, DELIVER = 1'b1} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]     wptr, rptr;
   logic                  push, accept;

   assign full  = (count == (ADDR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign push  = wen && !full;
   assign valid = (state == DELIVER);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (read_req && !empty) begin
               accept    = 1'b1;
               state_nxt = DELIVER;
            end
         end
         DELIVER: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else if (clr)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Storage is intentionally not reset; only the pointers define its contents.
   always_ff @(posedge clk) begin
      if (push && !clr)
         mem[wptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         dout     <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         dout     <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= wen && full;
         if (push)
            wptr <= wptr + 1'b1;
         if (accept) begin
            dout <= mem[rptr];
            rptr <= rptr + 1'b1;
         end
         // Simultaneous push and pop leave the count unchanged.
         case ({push, accept})
            2'b10:   count <= count + (ADDR_W+1)'(1);
            2'b01:   count <= count - (ADDR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_input_circular_buffer.sv
// Bench for input_circular_buffer: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_input_circular_buffer;

   localparam int DW = 16;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst, clr, wen, read_req;
   logic [DW-1:0] din, dout;
   logic          full, valid, empty, overflow;
   logic [3:0]    count;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] q [$];
   bit            m_valid;
   bit            m_ovf;
   logic [DW-1:0] m_dout;

   input_circular_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .clr(clr), .wen(wen), .din(din), .full(full),
      .read_req(read_req), .valid(valid), .dout(dout), .empty(empty),
      .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic model_clear();
      q.delete();
      m_valid = 0;
      m_ovf   = 0;
      m_dout  = '0;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, return 1ns after it.
   task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
      bit m_full, m_empty, acc;
      wen = w; din = d; read_req = r; clr = c;
      @(posedge clk);
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      if (c) begin
         model_clear();
      end else begin
         acc   = r && !m_empty && !m_valid;
         m_ovf = w && m_full;
         if (acc) m_dout = q.pop_front();
         if (w && !m_full) q.push_back(d);
         m_valid = acc;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; wen = 1'b0; read_req = 1'b0; din = '0;
      model_clear();
      #23;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", empty); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", full); end
      checks++; if (valid !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_valid_ovf: got %b/%b want 0/0", valid, overflow); end
      checks++; if (dout !== 16'h0) begin failures++; $display("FAIL reset_dout: got %h want 0000", dout); end
      rst = 1'b0;
      #4;
   endtask

   task automatic test_basic();
      logic [DW-1:0] exp_words [3];
      int n = 0;
      exp_words[0] = 16'hA1; exp_words[1] = 16'hA2; exp_words[2] = 16'hA3;
      for (int i = 0; i < 3; i++) drive(1'b1, exp_words[i], 1'b0, 1'b0);
      checks++; if (count !== 4'd3 || empty !== 1'b0) begin failures++; $display("FAIL basic_count: got count=%0d empty=%b want 3/0", count, empty); end
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         checks++;
         if (valid !== (i % 2 == 0)) begin failures++; $display("FAIL basic_valid_pattern: cycle %0d got %b want %b", i, valid, (i % 2 == 0)); end
         if (valid === 1'b1 && n < 3) begin
            checks++;
            if (dout !== exp_words[n]) begin failures++; $display("FAIL basic_dout: word %0d got %h want %h", n, dout, exp_words[n]); end
            n++;
         end
      end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty_after: got %b want 1", empty); end
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_full();
      logic [DW-1:0] exp_words [DEPTH];
      int n = 0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_words[i] = DW'($urandom);
         drive(1'b1, exp_words[i], 1'b0, 1'b0);
      end
      checks++; if (full !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL full_flag: got full=%b count=%0d want 1/8", full, count); end
      drive(1'b1, 16'hDEAD, 1'b0, 1'b0);
      checks++; if (overflow !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL full_overflow: got ovf=%b count=%0d want 1/8", overflow, count); end
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_overflow_pulse: got %b want 0", overflow); end
      for (int i = 0; i < 20 && n < DEPTH; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         if (valid === 1'b1) begin
            checks++;
            if (dout !== exp_words[n]) begin failures++; $display("FAIL full_drain_order: word %0d got %h want %h", n, dout, exp_words[n]); end
            n++;
         end
      end
      checks++; if (n != DEPTH || empty !== 1'b1) begin failures++; $display("FAIL full_drain_done: got words=%0d empty=%b want 8/1", n, empty); end
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_empty_wait();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         checks++; if (valid !== 1'b0) begin failures++; $display("FAIL empty_wait_valid: cycle %0d got %b want 0", i, valid); end
      end
      drive(1'b1, 16'h0055, 1'b1, 1'b0);
      checks++; if (valid !== 1'b0 || count !== 4'd1) begin failures++; $display("FAIL empty_push_cycle: got valid=%b count=%0d want 0/1", valid, count); end
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (valid !== 1'b1 || dout !== 16'h0055) begin failures++; $display("FAIL empty_deliver: got valid=%b dout=%h want 1/0055", valid, dout); end
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_full_simul();
      logic [DW-1:0] oldest;
      for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(16'h3000 + i), 1'b0, 1'b0);
      oldest = 16'h3000;
      drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
      checks++; if (overflow !== 1'b1 || count !== 4'd7) begin failures++; $display("FAIL simul_ovf_count: got ovf=%b count=%0d want 1/7", overflow, count); end
      checks++; if (valid !== 1'b1 || dout !== oldest) begin failures++; $display("FAIL simul_oldest: got valid=%b dout=%h want 1/%h", valid, dout, oldest); end
      for (int i = 0; i < 40 && (q.size() != 0 || m_valid); i++) drive(1'b0, '0, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL simul_drain: got empty=%b want 1", empty); end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] sent [$];
      int n_sent = 0, n_got = 0;
      for (int i = 0; i < 100 && n_got < 20; i++) begin
         if (n_sent < 20 && q.size() < DEPTH) begin
            sent.push_back(DW'(16'h7000 + n_sent));
            drive(1'b1, DW'(16'h7000 + n_sent), 1'b1, 1'b0);
            n_sent++;
         end else begin
            drive(1'b0, '0, 1'b1, 1'b0);
         end
         checks++; if (count > 4'd8 || overflow !== 1'b0) begin failures++; $display("FAIL wrap_bounds: got count=%0d ovf=%b want <=8/0", count, overflow); end
         if (valid === 1'b1) begin
            checks++;
            if (dout !== sent[n_got]) begin failures++; $display("FAIL wrap_order: word %0d got %h want %h", n_got, dout, sent[n_got]); end
            n_got++;
         end
      end
      checks++; if (n_got != 20) begin failures++; $display("FAIL wrap_total: got %0d words want 20", n_got); end
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) drive(1'b1, DW'(16'h9000 + i), 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (valid !== 1'b1 || count !== 4'd4) begin failures++; $display("FAIL rstmid_setup: got valid=%b count=%0d want 1/4", valid, count); end
      rst = 1'b1;
      #1;
      checks++; if (valid !== 1'b0 || dout !== 16'h0 || count !== 4'd0) begin failures++; $display("FAIL rstmid_async: got valid=%b dout=%h count=%0d want 0/0000/0", valid, dout, count); end
      #2;
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < 5; i++) drive(1'b1, DW'(16'h9100 + i), 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);
      clr = 1'b1; read_req = 1'b0;
      #1;
      checks++; if (valid !== 1'b1 || count !== 4'd4) begin failures++; $display("FAIL clrmid_before_edge: got valid=%b count=%0d want 1/4", valid, count); end
      drive(1'b1, 16'h1234, 1'b1, 1'b1);
      checks++; if (valid !== 1'b0 || dout !== 16'h0 || count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL clrmid_edge: got valid=%b dout=%h count=%0d empty=%b want 0/0000/0/1", valid, dout, count, empty); end
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic w, r, c;
      for (int i = 0; i < 400; i++) begin
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 50);
         c = ($urandom_range(0, 59) == 0);
         drive(w, DW'($urandom), r, c);
         checks++;
         if (count !== 4'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
            failures++; $display("FAIL rand_count: cycle %0d got count=%0d empty=%b full=%b want count=%0d", i, count, empty, full, q.size());
         end
         checks++;
         if (valid !== m_valid || overflow !== m_ovf || dout !== m_dout) begin
            failures++; $display("FAIL rand_outputs: cycle %0d got valid=%b ovf=%b dout=%h want %b/%b/%h", i, valid, overflow, dout, m_valid, m_ovf, m_dout);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_empty_wait();
      test_full_simul();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
